sprite_pose_ctrl: RTL

SPRITE_POSE_CTRL -- requirements
Module: sprite_pose_ctrl

---
 rtl/sprite_pose_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sprite_pose_ctrl.sv
// sprite_pose_ctrl
//   Once-per-frame sprite pose selector. On each falling edge of the active-low
//   vertical sync the player status word is snapshotted for the renderer and a
//   sprite pose is chosen from it. Action poses are held for a minimum number
//   of frames unless a higher-priority action preempts them. The walk pose
//   alternates between two frames every WALK_DIV frames.
//
// Parameters
//   HOLD_FRAMES  minimum frames an action pose stays on screen (1..15)
//   WALK_DIV     frames per walk-phase toggle (1..15)
//
// Ports
//   iVGA_CLK    in   1    pixel clock, all state changes on its rising edge
//   iRST_n      in   1    asynchronous active-low reset
//   iVS         in   1    vertical sync, active-low
//   pVGA        in   128  player status word
//   oSnap       out  128  pVGA latched at the frame tick
//   oPose       out  3    0 normal, 1 attack, 2 down, 3 down-B, 4 side-B,
//                         5 up-B, 6 B, 7 walk
//   oWalkPhase  out  1    alternate walk frame select
//   oFrameTick  out  1    one-cycle pulse following each frame update
module sprite_pose_ctrl #(
  parameter int HOLD_FRAMES = 6,
  parameter int WALK_DIV    = 8
) (
  input  logic         iVGA_CLK,
  input  logic         iRST_n,
  input  logic         iVS,
  input  logic [127:0] pVGA,
  output logic [127:0] oSnap,
  output logic [2:0]   oPose,
  output logic         oWalkPhase,
  output logic         oFrameTick
);

  localparam logic [2:0] POSE_NORMAL = 3'd0;
  localparam logic [2:0] POSE_ATTACK = 3'd1;
  localparam logic [2:0] POSE_DOWN   = 3'd2;
  localparam logic [2:0] POSE_DOWNB  = 3'd3;
  localparam logic [2:0] POSE_SIDEB  = 3'd4;
  localparam logic [2:0] POSE_UPB    = 3'd5;
  localparam logic [2:0] POSE_B      = 3'd6;
  localparam logic [2:0] POSE_WALK   = 3'd7;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_FRAMES - 1);
  localparam logic [3:0] WALK_LAST = 4'(WALK_DIV - 1);

  typedef enum logic {ST_FREE, ST_HOLD} state_t;

  state_t     r_state;
  logic       r_vs_q;
  logic [3:0] r_hold_cnt;
  logic [3:0] r_walk_cnt;

  logic       w_tick;
  logic [2:0] w_req;
  logic       w_preempt;
  logic [2:0] w_next_pose;
  logic [3:0] w_next_hold;
  state_t     w_next_state;

  // Requested pose from the live status word, highest priority first.
  function automatic logic [2:0] f_req_pose(input logic [127:0] v);
    logic [2:0] p;
    if (v[101])                               p = POSE_ATTACK;
    else if (v[103])                          p = POSE_DOWNB;
    else if (v[102])                          p = POSE_UPB;
    else if (v[104] || v[105])                p = POSE_SIDEB;
    else if (v[106])                          p = POSE_B;
    else if (v[71:69] == 3'b000 && v[113])    p = POSE_DOWN;
    else if (v[79:78] != 2'b10 && v[79:78] != 2'b01 && v[113])
                                              p = POSE_WALK;
    else                                      p = POSE_NORMAL;
    return p;
  endfunction

  // Priority rank of action poses; 0 marks a free pose.
  function automatic logic [2:0] f_rank(input logic [2:0] p);
    logic [2:0] r;
    case (p)
      POSE_ATTACK: r = 3'd5;
      POSE_DOWNB:  r = 3'd4;
      POSE_UPB:    r = 3'd3;
      POSE_SIDEB:  r = 3'd2;
      POSE_B:      r = 3'd1;
      default:     r = 3'd0;
    endcase
    return r;
  endfunction

  // vs_q resets to 0, so a reset released with iVS low cannot fake a fall.
  assign w_tick    = ~iVS & r_vs_q;
  assign w_req     = f_req_pose(pVGA);
  assign w_preempt = (f_rank(w_req) != 3'd0) && (f_rank(w_req) > f_rank(oPose));

  // Pose/hold decision evaluated every cycle, committed only on a tick.
  always_comb begin
    w_next_pose  = w_req;
    w_next_hold  = 4'd0;
    w_next_state = ST_FREE;
    if (r_state == ST_HOLD && w_preempt) begin
      w_next_hold  = HOLD_LOAD;
      w_next_state = ST_HOLD;
    end else if (r_state == ST_HOLD && r_hold_cnt != 4'd0) begin
      w_next_pose  = oPose;
      w_next_hold  = r_hold_cnt - 4'd1;
      w_next_state = ST_HOLD;
    end else if (f_rank(w_req) != 3'd0) begin
      // Expired hold falls through here, so a still-requested action reloads.
      w_next_hold  = HOLD_LOAD;
      w_next_state = ST_HOLD;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_vs_q     <= 1'b0;
      r_state    <= ST_FREE;
      r_hold_cnt <= 4'd0;
      r_walk_cnt <= 4'd0;
      oSnap      <= '0;
      oPose      <= POSE_NORMAL;
      oWalkPhase <= 1'b0;
      oFrameTick <= 1'b0;
    end else begin
      r_vs_q     <= iVS;
      oFrameTick <= w_tick;
      if (w_tick) begin
        oSnap      <= pVGA;
        oPose      <= w_next_pose;
        r_state    <= w_next_state;
        r_hold_cnt <= w_next_hold;
        // Walk phase only advances while walk is kept across ticks.
        if (w_next_pose == POSE_WALK && oPose == POSE_WALK) begin
          if (r_walk_cnt == WALK_LAST) begin
            r_walk_cnt <= 4'd0;
            oWalkPhase <= ~oWalkPhase;
          end else begin
            r_walk_cnt <= r_walk_cnt + 4'd1;
          end
        end else begin
          r_walk_cnt <= 4'd0;
          oWalkPhase <= 1'b0;
        end
      end
    end
  end

endmodule
